maze_player_ctrl: RTL and testbench
===================================

# maze_player_ctrl

- Sits directly downstream of the maze selector.
- Latches the selected maze, player start and player end on a load pulse.
- Turns debounced direction buttons into single-cell player moves, with wall and edge collision checks, optional hold-to-repeat, move counting and win detection.
- Its outputs drive the VGA renderer and the score/status display.

## Interface
- MAZE_W, 20, maze width in cells (columns)
- MAZE_H, 20, maze height in cells (rows)
- REPEAT_CYCLES, 12_500_000, hold-to-repeat interval in clk cycles; 0 disables repeat
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- load  in  1  one-cycle pulse: latch maze/start/end and begin a game
- maze  in  400  flattened maze; bit row*MAZE_W+col = 1 means wall
- player_start  in  10  start cell {row[4:0], col[4:0]}
- player_end  in  10  goal cell {row[4:0], col[4:0]}
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced, synchronous button levels
- player_pos  out  10  current cell {row, col}
- move_count  out  16  successful moves since load, saturating
- bump  out  1  one-cycle pulse when a requested move is blocked
- win  out  1  high while in WON
- playing  out  1  high in PLAY or CHECK

## Operation
- Internal registers: maze_q[399:0], end_q[9:0], target[9:0], btn_q[3:0] (previous levels), rep_cnt.
- press = btn & ~btn_q, bit order {up, down, left, right}.
- States and transitions:
  - IDLE: buttons are ignored.
  - load (any state, highest priority): maze_q←maze, player_pos←player_start, end_q←player_end, move_count←0, win←0, rep_cnt←0. Next state is WON if player_start==player_end, else PLAY.
  - PLAY, exactly one press bit set: compute target, go to CHECK.
  - PLAY, zero or ≥2 press bits: stay in PLAY, no bump.
  - CHECK, target blocked: bump←1, position unchanged, back to PLAY.
  - CHECK, target free: player_pos←target, move_count←move_count+1 (holds at 16'hFFFF). Next state is WON if target==end_q, else PLAY.
  - WON: buttons are ignored; only load or reset leaves it.
- Direction arithmetic: up = row−1, down = row+1, left = col−1, right = col+1.
- Edge blocking, independent of wall bits:
  - row==0 moving up
  - row==MAZE_H−1 moving down
  - col==0 moving left
  - col==MAZE_W−1 moving right
- Wall blocking: maze_q[target_row*MAZE_W+target_col]==1.
- Repeat:
  - In PLAY with exactly one button held and no new press, rep_cnt counts up.
  - When rep_cnt reaches REPEAT_CYCLES−1 it clears and a move request for the held direction is issued (same path as a press).
  - rep_cnt clears on any press, on release, when more than one button is held, and outside PLAY/CHECK.
  - REPEAT_CYCLES=0: no repeat at all.
- btn_q updates every cycle in every state, so a button held through load does not generate a press.
- Presses arriving while in CHECK are lost; rep_cnt does not advance in CHECK.

## Timing
- Reset values:
  - state IDLE; player_pos 0, move_count 0, bump 0, win 0, playing 0.
  - maze_q 0, end_q 0, btn_q 0, rep_cnt 0.
- Load latency: load sampled at edge N; player_pos, move_count and playing are valid after edge N; win is valid after edge N when start==end.
- Move latency: button rises before edge N; state is CHECK after edge N. At edge N+1:
  - player_pos/move_count update, or bump asserts for one cycle;
  - win asserts on reaching the goal.
- Minimum spacing between accepted presses is 2 cycles.
- Repeat: first repeated move is requested REPEAT_CYCLES PLAY-cycles after the initial press, then every REPEAT_CYCLES+1 cycles (the CHECK cycle is included).
- load in the same cycle as a press: load wins and the press is discarded.
- load while in CHECK: load wins and the pending move is discarded.
- rst_n low at any time, including mid-CHECK: all registers go to reset values immediately (asynchronously); no bump or move completes.
- maze/player_start/player_end must be stable in the cycle load is high; they are not used at any other time.

## Test plan
- Empty maze: border walls (rows 0 and 19, cols 0 and 19 set), interior clear.
  - Stimulus: start 10'b0100101001 (row 9, col 9), end 10'b0100101000 (row 9, col 8), load, then a left press.
  - Response: at press edge+1, player_pos=10'b0100101000, move_count=1, win=1, playing=0; further presses produce no change.
- Same empty maze, start row 1, col 5.
  - Stimulus: up press (target is a row 0 wall bit).
  - Response: bump is high for exactly 1 cycle, player_pos unchanged, move_count=0.
  - Stimulus: start row 5, col 0, then a left press.
  - Response: bump from edge blocking (even with the wall bit forced to 0), position unchanged.
- Simultaneous presses.
  - Stimulus: up and right rise in the same cycle.
  - Response: no move, no bump, state stays PLAY.
- Repeat, REPEAT_CYCLES=4, empty maze, start row 9, col 2.
  - Stimulus: right held for 20 cycles.
  - Response: col increments to 3 at press+1, then again every 5 cycles; move_count matches the number of moves.
  - Stimulus: REPEAT_CYCLES=0, same hold.
  - Response: exactly one move.
- Start equals end.
  - Stimulus: load with player_start==player_end.
  - Response: win=1 one cycle after load, move_count=0.
  - Stimulus: load again with different end.
  - Response: win=0, PLAY.
- Reset mid-CHECK.
  - Stimulus: rst_n driven low while in CHECK.
  - Response: player_pos=0 immediately, no bump, IDLE.
  - Stimulus: buttons pressed after reset release.
  - Response: ignored until load.

Source files
------------

// File: rtl/maze_player_ctrl.sv
// Player movement controller for the maze game: latches a maze on load, turns
// button presses (and optional hold-to-repeat) into checked single-cell moves.
module maze_player_ctrl #(
    parameter int unsigned MAZE_W        = 20,
    parameter int unsigned MAZE_H        = 20,
    parameter int unsigned REPEAT_CYCLES = 12_500_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [MAZE_W*MAZE_H-1:0]   maze,
    input  logic [9:0]                 player_start,
    input  logic [9:0]                 player_end,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_left,
    input  logic                       btn_right,
    output logic [9:0]                 player_pos,
    output logic [15:0]                move_count,
    output logic                       bump,
    output logic                       win,
    output logic                       playing
);

    localparam int unsigned CELLS = MAZE_W * MAZE_H;
    localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [4:0] ROW_LAST = 5'(MAZE_H - 1);
    localparam logic [4:0] COL_LAST = 5'(MAZE_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        CHECK,
        WON
    } state_t;

    state_t state, state_d;

    logic [CELLS-1:0] maze_q;
    logic [9:0]       end_q;
    logic [9:0]       target;
    logic             edge_q;
    logic [3:0]       btn_q;
    logic [REP_W-1:0] rep_cnt, rep_d;

    logic [3:0]       btn, press, req_dir;
    logic             req, do_load, do_move, do_bump;
    logic             blocked, wall_hit, edge_hit;
    logic [4:0]       cur_row, cur_col, tgt_row, tgt_col;
    logic [15:0]      idx_full;
    logic [IDX_W-1:0] idx;

    assign btn     = {btn_up, btn_down, btn_left, btn_right};
    assign press   = btn & ~btn_q;
    assign cur_row = player_pos[9:5];
    assign cur_col = player_pos[4:0];

    // Edge blocking is decided when the target is computed, before any wrap.
    always_comb begin
        tgt_row  = cur_row;
        tgt_col  = cur_col;
        edge_hit = 1'b0;
        if (req_dir[3]) begin
            edge_hit = (cur_row == 5'd0);
            tgt_row  = cur_row - 5'd1;
        end else if (req_dir[2]) begin
            edge_hit = (cur_row == ROW_LAST);
            tgt_row  = cur_row + 5'd1;
        end else if (req_dir[1]) begin
            edge_hit = (cur_col == 5'd0);
            tgt_col  = cur_col - 5'd1;
        end else if (req_dir[0]) begin
            edge_hit = (cur_col == COL_LAST);
            tgt_col  = cur_col + 5'd1;
        end
    end

    always_comb begin
        idx_full = 16'(target[9:5]) * 16'(MAZE_W) + 16'(target[4:0]);
        idx      = IDX_W'(idx_full);
        wall_hit = (idx_full < 16'(CELLS)) ? maze_q[idx] : 1'b1;
        blocked  = edge_q | wall_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        rep_d   = rep_cnt;
        req     = 1'b0;
        req_dir = '0;
        do_load = 1'b0;
        do_move = 1'b0;
        do_bump = 1'b0;
        if (load) begin
            do_load = 1'b1;
            rep_d   = '0;
            state_d = (player_start == player_end) ? WON : PLAY;
        end else begin
            unique case (state)
                PLAY: begin
                    if (press != 4'b0000) begin
                        rep_d = '0;
                        if ($onehot(press)) begin
                            req     = 1'b1;
                            req_dir = press;
                        end
                    end else if (REPEAT_CYCLES != 0 && $onehot(btn)) begin
                        if (rep_cnt == REP_LAST) begin
                            rep_d   = '0;
                            req     = 1'b1;
                            req_dir = btn;
                        end else begin
                            rep_d = rep_cnt + 1'b1;
                        end
                    end else begin
                        rep_d = '0;
                    end
                    if (req) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    // Counter is frozen here so the CHECK cycle adds one to the repeat period.
                    if (!$onehot(btn)) begin
                        rep_d = '0;
                    end
                    if (blocked) begin
                        do_bump = 1'b1;
                        state_d = PLAY;
                    end else begin
                        do_move = 1'b1;
                        state_d = (target == end_q) ? WON : PLAY;
                    end
                end
                default: begin
                    rep_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maze_q     <= '0;
            end_q      <= '0;
            target     <= '0;
            edge_q     <= 1'b0;
            btn_q      <= '0;
            rep_cnt    <= '0;
            player_pos <= '0;
            move_count <= '0;
            bump       <= 1'b0;
        end else begin
            btn_q   <= btn;
            rep_cnt <= rep_d;
            bump    <= do_bump;
            if (do_load) begin
                maze_q     <= maze;
                player_pos <= player_start;
                end_q      <= player_end;
                move_count <= '0;
            end else if (do_move) begin
                player_pos <= target;
                if (move_count != '1) begin
                    move_count <= move_count + 16'd1;
                end
            end
            if (req) begin
                target <= {tgt_row, tgt_col};
                edge_q <= edge_hit;
            end
        end
    end

    assign win     = (state == WON);
    assign playing = (state == PLAY) || (state == CHECK);

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed scoreboard bench for maze_player_ctrl: stimulus pushes expected
// output snapshots tagged with a cycle number, a negedge monitor checks them.
module tb_maze_player_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic [399:0] maze = '0;
    logic [9:0]   player_start = '0;
    logic [9:0]   player_end = '0;
    logic [3:0]   btns = '0;

    logic [9:0]  pos_a, pos_b;
    logic [15:0] mc_a, mc_b;
    logic        bump_a, bump_b, win_a, win_b, play_a, play_b;

    always #5 clk = ~clk;

    maze_player_ctrl #(.MAZE_W(20), .MAZE_H(20), .REPEAT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .maze(maze),
        .player_start(player_start), .player_end(player_end),
        .btn_up(btns[3]), .btn_down(btns[2]), .btn_left(btns[1]), .btn_right(btns[0]),
        .player_pos(pos_a), .move_count(mc_a), .bump(bump_a), .win(win_a), .playing(play_a)
    );

    maze_player_ctrl #(.MAZE_W(20), .MAZE_H(20), .REPEAT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .maze(maze),
        .player_start(player_start), .player_end(player_end),
        .btn_up(btns[3]), .btn_down(btns[2]), .btn_left(btns[1]), .btn_right(btns[0]),
        .player_pos(pos_b), .move_count(mc_b), .bump(bump_b), .win(win_b), .playing(play_b)
    );

    typedef struct {
        int unsigned cyc;
        bit          which;
        logic [9:0]  pos;
        logic [15:0] mc;
        logic        bump;
        logic        win;
        logic        playing;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    localparam logic [3:0] UP = 4'b1000, DOWN = 4'b0100, LEFT = 4'b0010, RIGHT = 4'b0001;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] rc(input int r, input int c);
        logic [4:0] rr, cc;
        rr = r[4:0];
        cc = c[4:0];
        return {rr, cc};
    endfunction

    function automatic logic [399:0] border_maze();
        logic [399:0] m;
        m = '0;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++)
                if (r == 0 || r == 19 || c == 0 || c == 19) m[r*20+c] = 1'b1;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int unsigned off, input bit which, input logic [9:0] p,
                             input logic [15:0] m, input logic b, input logic w,
                             input logic pl, input string nm);
        exp_t e;
        e.cyc = cyc + off; e.which = which; e.pos = p; e.mc = m;
        e.bump = b; e.win = w; e.playing = pl; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: every negedge, compare all snapshots due in this cycle.
    always @(negedge clk) begin
        logic [9:0]  ap;
        logic [15:0] am;
        logic        ab, aw, apl;
        bit          seen_a;
        int          i;
        seen_a = 1'b0;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                ap  = sb[i].which ? pos_b  : pos_a;
                am  = sb[i].which ? mc_b   : mc_a;
                ab  = sb[i].which ? bump_b : bump_a;
                aw  = sb[i].which ? win_b  : win_a;
                apl = sb[i].which ? play_b : play_a;
                if (!sb[i].which) seen_a = 1'b1;
                n_cmp++;
                if (sb[i].cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s: check for cycle %0d not reached in time (now %0d)",
                             sb[i].name, sb[i].cyc, cyc);
                end else if (ap !== sb[i].pos || am !== sb[i].mc || ab !== sb[i].bump ||
                             aw !== sb[i].win || apl !== sb[i].playing) begin
                    n_fail++;
                    $display("FAIL %s (dut%0d) cyc %0d: got pos=%03h mc=%0d bump=%b win=%b playing=%b, want pos=%03h mc=%0d bump=%b win=%b playing=%b",
                             sb[i].name, sb[i].which, cyc, ap, am, ab, aw, apl,
                             sb[i].pos, sb[i].mc, sb[i].bump, sb[i].win, sb[i].playing);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
        if (!seen_a && bump_a === 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious_bump cyc %0d: got bump=1, want bump=0", cyc);
        end
    end

    task automatic do_load(input logic [399:0] m, input logic [9:0] s, input logic [9:0] e,
                           input logic w, input string nm);
        maze = m; player_start = s; player_end = e; load = 1'b1;
        expect_at(1, 1'b0, s, 16'd0, 1'b0, w, !w, nm);
        tick();
        load = 1'b0;
    endtask

    // One-cycle press; result appears two edges after the drive point.
    task automatic press_move(input logic [3:0] dir, input logic [9:0] p, input logic [15:0] m,
                              input logic b, input logic w, input logic pl, input string nm);
        btns = dir;
        expect_at(2, 1'b0, p, m, b, w, pl, nm);
        if (b) expect_at(3, 1'b0, p, m, 1'b0, w, pl, {nm, "_one_cycle"});
        tick();
        btns = '0;
        tick();
        tick();
    endtask

    initial begin
        logic [399:0] bm;
        int unsigned  j;
        bm = border_maze();

        repeat (3) tick();
        expect_at(0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, "reset_held");
        tick();
        rst_n = 1'b1;
        expect_at(1, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, "reset_released");
        tick();
        tick();

        // Single move onto the goal, then WON ignores buttons.
        do_load(bm, 10'b0100101001, 10'b0100101000, 1'b0, "load_9_9");
        press_move(LEFT, 10'b0100101000, 16'd1, 1'b0, 1'b1, 1'b0, "win_move");
        press_move(LEFT, 10'b0100101000, 16'd1, 1'b0, 1'b1, 1'b0, "won_ignores");

        do_load(bm, rc(1, 5), rc(9, 9), 1'b0, "load_1_5");
        press_move(UP, rc(1, 5), 16'd0, 1'b1, 1'b0, 1'b1, "wall_bump");

        // Edge blocking with all wall bits clear.
        do_load('0, rc(0, 0), rc(9, 9), 1'b0, "load_0_0");
        press_move(UP, rc(0, 0), 16'd0, 1'b1, 1'b0, 1'b1, "edge_top");
        press_move(LEFT, rc(0, 0), 16'd0, 1'b1, 1'b0, 1'b1, "edge_left");
        do_load('0, rc(19, 19), rc(9, 9), 1'b0, "load_19_19");
        press_move(DOWN, rc(19, 19), 16'd0, 1'b1, 1'b0, 1'b1, "edge_bottom");
        press_move(RIGHT, rc(19, 19), 16'd0, 1'b1, 1'b0, 1'b1, "edge_right");
        press_move(UP, rc(18, 19), 16'd1, 1'b0, 1'b0, 1'b1, "free_up");
        press_move(UP | RIGHT, rc(18, 19), 16'd1, 1'b0, 1'b0, 1'b1, "simultaneous");
        press_move(DOWN, rc(19, 19), 16'd2, 1'b0, 1'b0, 1'b1, "after_simul");

        // Hold right for 20 edges: moves at +2, +7, +12, +17 (repeat 4); one move with repeat 0.
        do_load(bm, rc(9, 2), rc(1, 1), 1'b0, "load_rep");
        btns = RIGHT;
        expect_at(2,  1'b0, rc(9, 3), 16'd1, 1'b0, 1'b0, 1'b1, "rep_m1");
        expect_at(2,  1'b1, rc(9, 3), 16'd1, 1'b0, 1'b0, 1'b1, "norep_m1");
        expect_at(6,  1'b0, rc(9, 3), 16'd1, 1'b0, 1'b0, 1'b1, "rep_wait");
        expect_at(7,  1'b0, rc(9, 4), 16'd2, 1'b0, 1'b0, 1'b1, "rep_m2");
        expect_at(12, 1'b0, rc(9, 5), 16'd3, 1'b0, 1'b0, 1'b1, "rep_m3");
        expect_at(16, 1'b0, rc(9, 5), 16'd3, 1'b0, 1'b0, 1'b1, "rep_wait3");
        expect_at(17, 1'b0, rc(9, 6), 16'd4, 1'b0, 1'b0, 1'b1, "rep_m4");
        expect_at(21, 1'b0, rc(9, 6), 16'd4, 1'b0, 1'b0, 1'b1, "rep_release");
        expect_at(22, 1'b1, rc(9, 3), 16'd1, 1'b0, 1'b0, 1'b1, "norep_hold");
        repeat (20) tick();
        btns = '0;
        repeat (3) tick();

        do_load(bm, rc(4, 4), rc(4, 4), 1'b1, "start_is_end");
        do_load(bm, rc(4, 4), rc(4, 5), 1'b0, "reload_play");
        press_move(RIGHT, rc(4, 5), 16'd1, 1'b0, 1'b1, 1'b0, "reach_goal");

        // Load with a simultaneous press: press discarded.
        btns = LEFT;
        expect_at(2, 1'b0, rc(6, 6), 16'd0, 1'b0, 1'b0, 1'b1, "load_press_discard");
        expect_at(3, 1'b0, rc(6, 6), 16'd0, 1'b0, 1'b0, 1'b1, "load_press_discard2");
        do_load(bm, rc(6, 6), rc(1, 1), 1'b0, "load_with_press");
        btns = '0;
        tick();
        tick();

        // Load while CHECK is pending.
        btns = UP;
        tick();
        btns = '0;
        expect_at(2, 1'b0, rc(3, 3), 16'd0, 1'b0, 1'b0, 1'b1, "load_in_check2");
        do_load(bm, rc(3, 3), rc(1, 1), 1'b0, "load_in_check");
        tick();
        tick();

        // Asynchronous reset while in CHECK.
        do_load(bm, rc(9, 9), rc(1, 1), 1'b0, "load_pre_reset");
        btns = UP;
        tick();
        btns = '0;
        rst_n = 1'b0;
        expect_at(0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, "reset_mid_check");
        tick();
        expect_at(0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, "reset_no_bump");
        rst_n = 1'b1;
        tick();
        press_move(RIGHT, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, "idle_ignores");

        // Button held through load must not count as a press.
        btns = DOWN;
        tick();
        do_load(bm, rc(2, 2), rc(1, 1), 1'b0, "load_held_btn");
        expect_at(2, 1'b0, rc(2, 2), 16'd0, 1'b0, 1'b0, 1'b1, "held_no_press");
        expect_at(3, 1'b0, rc(2, 2), 16'd0, 1'b0, 1'b0, 1'b1, "held_no_press2");
        tick();
        btns = '0;
        repeat (4) tick();

        for (int t = 0; t < 20 && sb.size() > 0; t++) tick();
        while (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: expected check never performed", sb[0].name);
            void'(sb.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
